audio_source_arbiter: RTL and testbench
=======================================

// Module: audio_source_arbiter
// PURPOSE
//  Shares the single stereo sample path feeding the I2S bridge between NUM_SOURCES requesters (core buzzer, UI click, ...).
//  Fixed priority (index 0 highest); owner changes only via gain ramp-down/ramp-up to avoid pops. Global mute ramps to silence.
//  Sits in clk_audio domain directly ahead of the I2S bridge's audio_l/audio_r inputs (unsigned samples, 0 = silence).
// PARAMETERS
//  NUM_SOURCES    2    requester count, 2..8
//  CHANNEL_WIDTH  15   unsigned sample width per channel, <=15
//  RAMP_DIV       256  clk_audio cycles per gain step, >=1
//  GAIN_STEP      1    gain increment/decrement per step, 1..256
// PORTS
//  clk_audio    in   1                        audio clock
//  reset_n      in   1                        synchronous, active-low reset
//  mute         in   1                        level; 1 = ramp to silence and release grant
//  src_req      in   NUM_SOURCES              level request per source
//  src_audio_l  in   NUM_SOURCES*CHANNEL_WIDTH  packed left samples, source i at [i*W +: W]
//  src_audio_r  in   NUM_SOURCES*CHANNEL_WIDTH  packed right samples
//  audio_l      out  CHANNEL_WIDTH            scaled left sample to I2S bridge
//  audio_r      out  CHANNEL_WIDTH            scaled right sample
//  grant        out  NUM_SOURCES              one-hot owner, all-zero when IDLE
//  busy         out  1                        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, gain=0, grant=0, busy=0, audio_l=audio_r=0, prescaler=0; applies mid-ramp too.
//  gain: 9-bit, 0..256 (256 = unity). Steps saturate: up min(gain+STEP,256), down max(gain-STEP,0).
//  tick: prescaler counts 0..RAMP_DIV-1, tick when ==RAMP_DIV-1; prescaler cleared on every state change.
//  best = lowest index i with src_req[i]=1; "preempt" = best exists and best < owner index.
//  States:
//   IDLE:      gain=0. If !mute && |src_req: latch owner=best, grant=onehot(best), -> RAMP_UP same edge.
//   RAMP_UP:   on tick gain steps up; gain reaching 256 -> PLAY.
//              mute | !src_req[owner] | preempt -> RAMP_DOWN from current gain (no step that cycle).
//   PLAY:      gain=256. mute | !src_req[owner] | preempt -> RAMP_DOWN.
//   RAMP_DOWN: on tick gain steps down; gain reaching 0 -> IDLE, grant cleared same edge.
//              Requests/preempt ignored here; owner keeps grant until gain=0 (no reversal mid-ramp).
//  Priority of exits in RAMP_UP/PLAY: all three conditions equivalent (all go RAMP_DOWN); mute checked first only for IDLE entry.
//  After RAMP_DOWN->IDLE, IDLE re-arbitrates next cycle (1 cycle of gain=0 between owners, min).
//  Datapath: audio_x <= (src_audio_x[owner] * gain) >> 8, registered; 1-cycle latency from sample/gain change.
//   Product width CHANNEL_WIDTH+9; gain=256 yields exact input; gain=0 yields 0. In IDLE output forced 0.
//  Samples from non-owner sources never reach the output. Owner index register held constant outside IDLE.
//  grant changes only on IDLE exit/entry; busy = (state != IDLE), registered.
// STRUCTURE
//  audio_pkg: typedef enum logic [1:0] {ST_IDLE, ST_RAMP_UP, ST_PLAY, ST_RAMP_DOWN} arb_state_t;
//   localparams GAIN_BITS=9, GAIN_UNITY=9'd256.
//  Sub-module audio_gain_scaler (one per channel): CHANNEL_WIDTH sample x 9-bit gain, registered >>8 output.
//  Top holds FSM, prescaler, priority encoder, owner mux.
// TESTING  (RAMP_DIV=2, GAIN_STEP=64, W=15, N=2 unless stated)
//  Single source: src_req=01, src0 L=R=15'h4000 -> gain 64,128,192,256 every 2 clk; output 0x1000,0x2000,0x3000,0x4000; PLAY.
//  Preempt: src1 in PLAY, raise src_req[0] -> ramp down to 0 (grant=10 throughout), IDLE 1 cycle, grant=01, ramp up.
//  Release mid-ramp: src0 drops req at gain=128 in RAMP_UP -> RAMP_DOWN from 128, 0 after 4 clk, grant=00, busy=0.
//  Mute: mute=1 in PLAY with both req high -> ramp to 0, stays IDLE, output 0; mute=0 -> src0 granted.
//  Reset mid-ramp: reset_n=0 at gain=192 -> next edge audio_l=audio_r=0, grant=0, busy=0; release, resumes from IDLE.
//  No lower-priority preempt: src0 in PLAY, raise src_req[1] -> grant stays 01, gain stays 256.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared types and constants for the audio source arbiter.
//   arb_state_t : arbiter FSM state encoding
//   GAIN_BITS   : gain register width (0..256, 256 = unity)
//   gain_inc/gain_dec : saturating gain step helpers
package audio_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP_UP, ST_PLAY, ST_RAMP_DOWN} arb_state_t;

  localparam int GAIN_BITS = 9;
  localparam logic [GAIN_BITS-1:0] GAIN_UNITY = 9'd256;

  // Step is carried one bit wider so a full-scale step of 256 is representable.
  function automatic logic [GAIN_BITS-1:0] gain_inc(input logic [GAIN_BITS-1:0] g,
                                                    input logic [GAIN_BITS:0]   step);
    logic [GAIN_BITS:0] sum;
    sum = {1'b0, g} + step;
    return (sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : sum[GAIN_BITS-1:0];
  endfunction

  function automatic logic [GAIN_BITS-1:0] gain_dec(input logic [GAIN_BITS-1:0] g,
                                                    input logic [GAIN_BITS:0]   step);
    logic [GAIN_BITS:0] diff;
    diff = {1'b0, g} - step;
    return ({1'b0, g} > step) ? diff[GAIN_BITS-1:0] : '0;
  endfunction

endpackage

// File: rtl/audio_gain_scaler.sv
// audio_gain_scaler
//   Scales one unsigned audio channel by a 9-bit gain (256 = unity), registered.
//   clk_audio : audio clock
//   reset_n   : synchronous active-low reset, clears the output
//   sample    : unsigned input sample
//   gain      : 0..256
//   scaled    : (sample * gain) >> 8, one cycle later
module audio_gain_scaler
  import audio_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 15
) (
  input  logic                     clk_audio,
  input  logic                     reset_n,
  input  logic [CHANNEL_WIDTH-1:0] sample,
  input  logic [GAIN_BITS-1:0]     gain,
  output logic [CHANNEL_WIDTH-1:0] scaled
);

  logic [CHANNEL_WIDTH+GAIN_BITS-1:0] product;

  assign product = {{GAIN_BITS{1'b0}}, sample} * {{CHANNEL_WIDTH{1'b0}}, gain};

  // gain <= 256 keeps (product >> 8) within CHANNEL_WIDTH bits.
  always_ff @(posedge clk_audio) begin
    if (!reset_n) begin
      scaled <= '0;
    end else begin
      scaled <= CHANNEL_WIDTH'(product >> 8);
    end
  end

endmodule

// File: rtl/audio_source_arbiter.sv
// audio_source_arbiter
//   Fixed-priority (index 0 highest) owner of the stereo path into the I2S
//   bridge. Ownership changes only through a gain ramp down to 0 and back up,
//   so switching sources or muting never pops.
//   clk_audio, reset_n         : clock, synchronous active-low reset
//   mute                       : ramp to silence and release the grant
//   src_req                    : level request per source
//   src_audio_l / src_audio_r  : packed samples, source i at [i*W +: W]
//   audio_l / audio_r          : scaled owner samples (registered)
//   grant                      : one-hot owner, zero when idle
//   busy                       : state != IDLE
//
//   state        | meaning
//   ST_IDLE      | gain 0, no owner, arbitrate when not muted
//   ST_RAMP_UP   | owner latched, gain rises one step per tick
//   ST_PLAY      | gain at unity
//   ST_RAMP_DOWN | gain falls to 0, then grant released; no reversal
module audio_source_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_SOURCES   = 2,
  parameter int CHANNEL_WIDTH = 15,
  parameter int RAMP_DIV      = 256,
  parameter int GAIN_STEP     = 1
) (
  input  logic                                 clk_audio,
  input  logic                                 reset_n,
  input  logic                                 mute,
  input  logic [NUM_SOURCES-1:0]               src_req,
  input  logic [NUM_SOURCES*CHANNEL_WIDTH-1:0] src_audio_l,
  input  logic [NUM_SOURCES*CHANNEL_WIDTH-1:0] src_audio_r,
  output logic [CHANNEL_WIDTH-1:0]             audio_l,
  output logic [CHANNEL_WIDTH-1:0]             audio_r,
  output logic [NUM_SOURCES-1:0]               grant,
  output logic                                 busy
);

  localparam int OWN_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [GAIN_BITS:0] STEP     = (GAIN_BITS + 1)'(GAIN_STEP);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(RAMP_DIV - 1);

  arb_state_t             state, state_next;
  logic [GAIN_BITS-1:0]   gain, gain_next, gain_eff;
  logic [PRE_W-1:0]       pre, pre_next;
  logic [OWN_W-1:0]       owner, owner_next, best_idx;
  logic                   best_valid, tick, preempt, leave;
  logic [CHANNEL_WIDTH-1:0] mux_l, mux_r;

  // Lowest requesting index wins; scan high to low so the last hit is lowest.
  always_comb begin
    best_valid = 1'b0;
    best_idx   = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        best_valid = 1'b1;
        best_idx   = OWN_W'(i);
      end
    end
  end

  assign tick    = (pre == PRE_LAST);
  assign preempt = best_valid && (best_idx < owner);
  assign leave   = mute || !src_req[owner] || preempt;

  always_ff @(posedge clk_audio) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      gain  <= '0;
      pre   <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      gain  <= gain_next;
      pre   <= pre_next;
      owner <= owner_next;
    end
  end

  // A ramp step and a state change never share a prescaler count: every
  // transition clears it, so each ramp phase starts a full RAMP_DIV period.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    pre_next   = pre;
    owner_next = owner;
    case (state)
      ST_IDLE: begin
        gain_next = '0;
        pre_next  = '0;
        if (!mute && best_valid) begin
          state_next = ST_RAMP_UP;
          owner_next = best_idx;
        end
      end
      ST_RAMP_UP: begin
        if (leave) begin
          state_next = ST_RAMP_DOWN;
          pre_next   = '0;
        end else if (tick) begin
          gain_next = gain_inc(gain, STEP);
          pre_next  = '0;
          if (gain_next == GAIN_UNITY) state_next = ST_PLAY;
        end else begin
          pre_next = pre + 1'b1;
        end
      end
      ST_PLAY: begin
        gain_next = GAIN_UNITY;
        pre_next  = '0;
        if (leave) state_next = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (tick) begin
          gain_next = gain_dec(gain, STEP);
          pre_next  = '0;
          if (gain_next == '0) state_next = ST_IDLE;
        end else begin
          pre_next = pre + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state != ST_IDLE) grant[owner] = 1'b1;
    busy     = (state != ST_IDLE);
    gain_eff = (state == ST_IDLE) ? '0 : gain;
    mux_l    = src_audio_l[owner*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    mux_r    = src_audio_r[owner*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  end

  audio_gain_scaler #(.CHANNEL_WIDTH(CHANNEL_WIDTH)) u_scale_l (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .sample    (mux_l),
    .gain      (gain_eff),
    .scaled    (audio_l)
  );

  audio_gain_scaler #(.CHANNEL_WIDTH(CHANNEL_WIDTH)) u_scale_r (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .sample    (mux_r),
    .gain      (gain_eff),
    .scaled    (audio_r)
  );

endmodule

// File: tb/tb_audio_source_arbiter.sv
module tb_audio_source_arbiter;

  localparam int N    = 2;
  localparam int W    = 15;
  localparam int RDIV = 2;
  localparam int STEP = 64;

  logic          clk_audio = 1'b0;
  logic          reset_n   = 1'b0;
  logic          mute      = 1'b0;
  logic [N-1:0]  src_req   = '0;
  logic [W-1:0]  sl0 = '0, sr0 = '0, sl1 = '0, sr1 = '0;
  logic [N*W-1:0] src_audio_l, src_audio_r;
  logic [W-1:0]  audio_l, audio_r;
  logic [N-1:0]  grant;
  logic          busy;

  assign src_audio_l = {sl1, sl0};
  assign src_audio_r = {sr1, sr0};

  audio_source_arbiter #(
    .NUM_SOURCES(N), .CHANNEL_WIDTH(W), .RAMP_DIV(RDIV), .GAIN_STEP(STEP)
  ) dut (
    .clk_audio   (clk_audio),
    .reset_n     (reset_n),
    .mute        (mute),
    .src_req     (src_req),
    .src_audio_l (src_audio_l),
    .src_audio_r (src_audio_r),
    .audio_l     (audio_l),
    .audio_r     (audio_r),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 clk_audio = ~clk_audio;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk_audio);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    src_req = '0;
    mute    = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  // Reference model: owner, gain level as an integer and cycles since the
  // last gain step; outputs follow the gain/owner held before each edge.
  bit m_active;
  int m_phase;   // 0 rising, 1 full, 2 falling
  int m_gain, m_cnt, m_owner;
  int e_l, e_r, e_grant, e_busy;

  task automatic model_step();
    int best;
    int ol, orr;
    best = -1;
    for (int i = N - 1; i >= 0; i--) if (src_req[i]) best = i;
    if (!reset_n) begin
      e_l = 0; e_r = 0;
      m_active = 0; m_gain = 0; m_cnt = 0; m_owner = 0; m_phase = 0;
    end else begin
      ol  = (m_owner == 0) ? int'(sl0) : int'(sl1);
      orr = (m_owner == 0) ? int'(sr0) : int'(sr1);
      e_l = m_active ? (ol * m_gain) / 256 : 0;
      e_r = m_active ? (orr * m_gain) / 256 : 0;
      if (!m_active) begin
        m_gain = 0;
        if (!mute && best >= 0) begin
          m_active = 1; m_owner = best; m_phase = 0; m_cnt = 0;
        end
      end else if (m_phase != 2 &&
                   (mute || !src_req[m_owner] || (best >= 0 && best < m_owner))) begin
        m_phase = 2; m_cnt = 0;
      end else if (m_phase != 1) begin
        m_cnt++;
        if (m_cnt == RDIV) begin
          m_cnt = 0;
          if (m_phase == 0) begin
            m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
            if (m_gain == 256) m_phase = 1;
          end else begin
            m_gain = (m_gain - STEP < 0) ? 0 : m_gain - STEP;
            if (m_gain == 0) m_active = 0;
          end
        end
      end
    end
    e_grant = m_active ? (1 << m_owner) : 0;
    e_busy  = m_active ? 1 : 0;
  endtask

  typedef struct {
    bit           mute;
    bit [1:0]     req;
    bit [W-1:0]   l0, r0;
    bit [1:0]     grant;
    bit           busy;
    bit [W-1:0]   el, er;
  } vec_t;

  vec_t vt[26];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit grant_ok;

    // single source ramp up, no lower-priority preempt, sample change, mute
    vt[0]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h0000, 15'h0000};
    vt[1]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h0000, 15'h0000};
    vt[2]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h0000, 15'h0000};
    vt[3]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h1000, 15'h1000};
    vt[4]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h1000, 15'h1000};
    vt[5]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h2000, 15'h2000};
    vt[6]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h2000, 15'h2000};
    vt[7]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h3000, 15'h3000};
    vt[8]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h3000, 15'h3000};
    vt[9]  = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h4000, 15'h4000};
    vt[10] = '{1'b0, 2'b01, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h4000, 15'h4000};
    vt[11] = '{1'b0, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h4000, 15'h4000};
    vt[12] = '{1'b0, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h4000, 15'h4000};
    vt[13] = '{1'b0, 2'b11, 15'h1234, 15'h0F0F, 2'b01, 1'b1, 15'h1234, 15'h0F0F};
    vt[14] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h4000, 15'h4000};
    vt[15] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h4000, 15'h4000};
    vt[16] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h4000, 15'h4000};
    vt[17] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h3000, 15'h3000};
    vt[18] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h3000, 15'h3000};
    vt[19] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h2000, 15'h2000};
    vt[20] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h2000, 15'h2000};
    vt[21] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h1000, 15'h1000};
    vt[22] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b00, 1'b0, 15'h1000, 15'h1000};
    vt[23] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b00, 1'b0, 15'h0000, 15'h0000};
    vt[24] = '{1'b1, 2'b11, 15'h4000, 15'h4000, 2'b00, 1'b0, 15'h0000, 15'h0000};
    vt[25] = '{1'b0, 2'b11, 15'h4000, 15'h4000, 2'b01, 1'b1, 15'h0000, 15'h0000};

    // reset dominates an active request
    reset_n = 1'b0; src_req = 2'b01; sl0 = 15'h4000; sr0 = 15'h4000;
    sl1 = 15'h7FFF; sr1 = 15'h5555;
    cycle(); cycle(); cycle();
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_audio_l", audio_l, 0);
    check("reset_audio_r", audio_r, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      mute = vt[i].mute; src_req = vt[i].req; sl0 = vt[i].l0; sr0 = vt[i].r0;
      cycle();
      check($sformatf("vec%0d_grant", i), grant, vt[i].grant);
      check($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      check($sformatf("vec%0d_audio_l", i), audio_l, vt[i].el);
      check($sformatf("vec%0d_audio_r", i), audio_r, vt[i].er);
    end

    // preempt: src1 playing, src0 arrives
    do_reset();
    src_req = 2'b10; sl1 = 15'h2000; sr1 = 15'h2000;
    for (int i = 0; i < 10; i++) cycle();
    check("pre_play_grant", grant, 2'b10);
    check("pre_play_audio", audio_l, 15'h2000);
    src_req = 2'b11;
    n = 0; grant_ok = 1;
    while (busy && n < 20) begin
      cycle(); n++;
      if (busy && grant != 2'b10) grant_ok = 0;
    end
    check("pre_down_cycles", n, 9);
    check("pre_grant_held", grant_ok, 1);
    check("pre_idle_grant", grant, 0);
    check("pre_last_audio", audio_l, 15'h0800);
    cycle();
    check("pre_new_grant", grant, 2'b01);
    check("pre_new_busy", busy, 1);

    // release mid ramp at gain 128
    do_reset();
    src_req = 2'b01; sl0 = 15'h4000; sr0 = 15'h4000;
    for (int i = 0; i < 5; i++) cycle();
    check("rel_audio_g64", audio_l, 15'h1000);
    src_req = 2'b00;
    cycle();
    check("rel_audio_g128", audio_l, 15'h2000);
    n = 1;
    while (busy && n < 20) begin cycle(); n++; end
    check("rel_down_cycles", n, 5);
    check("rel_grant", grant, 0);
    cycle();
    check("rel_audio_zero", audio_r, 0);

    // reset mid ramp at gain 192
    do_reset();
    src_req = 2'b01;
    for (int i = 0; i < 7; i++) cycle();
    check("rst_mid_audio", audio_l, 15'h2000);
    reset_n = 1'b0;
    cycle();
    check("rst_mid_audio_l", audio_l, 0);
    check("rst_mid_audio_r", audio_r, 0);
    check("rst_mid_grant", grant, 0);
    check("rst_mid_busy", busy, 0);
    reset_n = 1'b1;
    cycle();
    check("rst_resume_grant", grant, 2'b01);
    check("rst_resume_audio", audio_l, 0);
    for (int i = 0; i < 9; i++) cycle();
    check("rst_resume_play", audio_l, 15'h4000);

    // randomized run against the model
    reset_n = 1'b0; src_req = '0; mute = 1'b0;
    @(posedge clk_audio); model_step(); #1;
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 29) == 0) src_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      sl0 = 15'($urandom); sr0 = 15'($urandom);
      sl1 = 15'($urandom); sr1 = 15'($urandom);
      @(posedge clk_audio);
      model_step();
      #1;
      check("rand_grant", grant, e_grant);
      check("rand_busy", busy, e_busy);
      check("rand_audio_l", audio_l, e_l);
      check("rand_audio_r", audio_r, e_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
